// File: rtl/dbuf_pkg.sv
// Shared types and constants for the ping-pong AXI write initiator.
// Latency: none (declarations only).
// Backpressure: not applicable.
package dbuf_pkg;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} drain_state_t;
   typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // AxSIZE encoding: log2 of the number of bytes per beat.
   function automatic logic [2:0] axi_size_f(input int unsigned data_w);
      return 3'($clog2(data_w / 8));
   endfunction

endpackage

// File: rtl/double_buffer_mst_bank.sv
// One BURST_LEN-deep beat store: synchronous write port, registered read port.
// Latency: read data appears one clock after the read address is presented.
// Backpressure: none; the caller guarantees a bank is never read while being written.
module pingpong_bank #(
   parameter int DW_g    = 64,
   parameter int DEPTH_g = 16
) (
   input  logic                       clk_i,
   input  logic                       wr_en_i,
   input  logic [$clog2(DEPTH_g)-1:0] wr_addr_i,
   input  logic [DW_g-1:0]            wr_data_i,
   input  logic [$clog2(DEPTH_g)-1:0] rd_addr_i,
   output logic [DW_g-1:0]            rd_data_o
);

   logic [DW_g-1:0] mem_q [DEPTH_g];
   logic [DW_g-1:0] rd_data_q;

   // Storage write and registered read; contents need no reset.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/double_buffer_mst.sv
// AXI4 write initiator: fills two ping-pong banks from a stream, drains each full bank as one INCR burst.
// Latency: AW issued two clocks after the beat that fills a bank; W beats follow the AW handshake.
// Backpressure: stall_o rises while the bank being filled is still FULL; AXI readies stall the drain FSM.
module double_buffer_mst
   import dbuf_pkg::*;
#(
   parameter int AXI_DW_g    = 64,
   parameter int AXI_AW_g    = 32,
   parameter int BURST_LEN_g = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [AXI_AW_g-1:0]     base_addr_i,
   input  logic                    load_addr_i,
   input  logic                    push_i,
   input  logic [AXI_DW_g-1:0]     data_i,
   output logic                    stall_o,
   input  logic                    m_axi_awready_i,
   output logic                    m_axi_awvalid_o,
   output logic [AXI_AW_g-1:0]     m_axi_awaddr_o,
   output logic [7:0]              m_axi_awlen_o,
   output logic [2:0]              m_axi_awsize_o,
   output logic [1:0]              m_axi_awburst_o,
   output logic [2:0]              m_axi_awprot_o,
   output logic [3:0]              m_axi_awcache_o,
   input  logic                    m_axi_wready_i,
   output logic                    m_axi_wvalid_o,
   output logic [AXI_DW_g-1:0]     m_axi_wdata_o,
   output logic [AXI_DW_g/8-1:0]   m_axi_wstrb_o,
   output logic                    m_axi_wlast_o,
   output logic                    m_axi_bready_o,
   input  logic                    m_axi_bvalid_i,
   input  logic [1:0]              m_axi_bresp_i,
   output logic                    err_o,
   output logic                    idle_o
);

   localparam int                  CNT_W       = $clog2(BURST_LEN_g);
   localparam logic [CNT_W-1:0]    LAST_BEAT   = CNT_W'(BURST_LEN_g - 1);
   localparam logic [AXI_AW_g-1:0] BURST_BYTES = AXI_AW_g'(BURST_LEN_g * (AXI_DW_g / 8));

   drain_state_t        state_q, state_d;
   bank_state_t         bank_q [2];
   bank_state_t         bank_d [2];
   logic                fill_idx_q, fill_idx_d;
   logic                drain_idx_q, drain_idx_d;
   logic [CNT_W-1:0]    fill_cnt_q, fill_cnt_d;
   logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
   logic [AXI_AW_g-1:0] addr_q, addr_d;
   logic                err_q, err_d;

   logic                accept;
   logic                idle;
   logic [CNT_W-1:0]    rd_addr;
   logic [AXI_DW_g-1:0] rd_data [2];

   assign stall_o = (bank_q[fill_idx_q] == FULL);
   assign accept  = push_i && !stall_o;
   assign idle    = (state_q == IDLE) && (bank_q[0] == EMPTY) && (bank_q[1] == EMPTY);

   for (genvar g = 0; g < 2; g++) begin : g_bank
      pingpong_bank #(
         .DW_g    (AXI_DW_g),
         .DEPTH_g (BURST_LEN_g)
      ) u_bank (
         .clk_i     (clk_i),
         .wr_en_i   (accept && (fill_idx_q == 1'(g))),
         .wr_addr_i (fill_cnt_q),
         .wr_data_i (data_i),
         .rd_addr_i (rd_addr),
         .rd_data_o (rd_data[g])
      );
   end

   // Drain FSM: AW first, then W beats prefetched one address ahead so wdata is ready with wvalid, then B.
   always_comb begin
      state_d         = state_q;
      beat_cnt_d      = beat_cnt_q;
      rd_addr         = '0;
      m_axi_awvalid_o = 1'b0;
      m_axi_wvalid_o  = 1'b0;
      m_axi_bready_o  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bank_q[drain_idx_q] == FULL) begin
               state_d = ADDR;
            end
         end
         ADDR: begin
            m_axi_awvalid_o = 1'b1;
            if (m_axi_awready_i) begin
               state_d    = DATA;
               beat_cnt_d = '0;
            end
         end
         DATA: begin
            m_axi_wvalid_o = 1'b1;
            rd_addr        = beat_cnt_q;
            if (m_axi_wready_i) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               rd_addr    = beat_cnt_d;
               if (beat_cnt_q == LAST_BEAT) begin
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            m_axi_bready_o = 1'b1;
            if (m_axi_bvalid_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bank bookkeeping: fill side and release side always touch different banks.
   always_comb begin
      bank_d      = bank_q;
      fill_idx_d  = fill_idx_q;
      fill_cnt_d  = fill_cnt_q;
      drain_idx_d = drain_idx_q;
      addr_d      = addr_q;
      err_d       = err_q;
      if (accept) begin
         if (fill_cnt_q == LAST_BEAT) begin
            bank_d[fill_idx_q] = FULL;
            fill_idx_d         = ~fill_idx_q;
            fill_cnt_d         = '0;
         end else begin
            bank_d[fill_idx_q] = FILLING;
            fill_cnt_d         = fill_cnt_q + 1'b1;
         end
      end
      if ((state_q == RESP) && m_axi_bvalid_i) begin
         bank_d[drain_idx_q] = EMPTY;
         drain_idx_d         = ~drain_idx_q;
         addr_d              = addr_q + BURST_BYTES;
         if (m_axi_bresp_i != AXI_RESP_OKAY) begin
            err_d = 1'b1;
         end
      end
      if (load_addr_i && idle) begin
         addr_d = base_addr_i;
      end
   end

   // State registers with synchronous reset; reset abandons any burst in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         bank_q[0]   <= EMPTY;
         bank_q[1]   <= EMPTY;
         fill_idx_q  <= 1'b0;
         drain_idx_q <= 1'b0;
         fill_cnt_q  <= '0;
         beat_cnt_q  <= '0;
         addr_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         bank_q      <= bank_d;
         fill_idx_q  <= fill_idx_d;
         drain_idx_q <= drain_idx_d;
         fill_cnt_q  <= fill_cnt_d;
         beat_cnt_q  <= beat_cnt_d;
         addr_q      <= addr_d;
         err_q       <= err_d;
      end
   end

   assign m_axi_awaddr_o  = addr_q;
   assign m_axi_awlen_o   = 8'(BURST_LEN_g - 1);
   assign m_axi_awsize_o  = axi_size_f(AXI_DW_g);
   assign m_axi_awburst_o = AXI_BURST_INCR;
   assign m_axi_awprot_o  = 3'b000;
   assign m_axi_awcache_o = 4'b0000;
   assign m_axi_wdata_o   = rd_data[drain_idx_q];
   assign m_axi_wstrb_o   = '1;
   assign m_axi_wlast_o   = (state_q == DATA) && (beat_cnt_q == LAST_BEAT);
   assign err_o           = err_q;
   assign idle_o          = idle;

endmodule
